// File: rtl/serial_parity_rx.sv
`default_nettype none
// ============================================================================
// Module   : serial_parity_rx
// Brief    : Bit-serial frame receiver with parity check. A frame is a start
//            bit (0), DATA_W data bits LSB first, one parity bit, and a stop
//            bit (1). The block emits the word with a one-cycle done strobe
//            and a parity-error flag.
// Options  : SERIAL_PARITY_RX_EVEN_EN - check even parity instead of odd.
// Revision : 1.0 - initial release
// ============================================================================
module serial_parity_rx #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in,
    output logic [DATA_W-1:0] out_byte,
    output logic              done,
    output logic              perr
);

    // The counter only has to reach DATA_W-1. Keep it at least one bit wide.
    localparam int                CNT_W  = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0]  C_LAST = CNT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0]  C_ONE  = CNT_W'(1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_DATA   = 3'd1,
        S_PARITY = 3'd2,
        S_STOP   = 3'd3,
        S_DONE   = 3'd4,
        S_WAIT   = 3'd5
    } state_t;

    state_t              state_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [DATA_W-1:0]   shift_q;
    logic [DATA_W-1:0]   shift_d;
    logic                acc_q;
    logic                perr_d;
    logic [DATA_W-1:0]   out_byte_q;
    logic                done_q;
    logic                perr_q;

    // The shift register moves right and the new bit enters at the MSB.
    // After DATA_W shifts, bit k is at position k.
    always_comb begin
        shift_d = shift_q;
        for (int i = 0; i < DATA_W - 1; i++) begin
            shift_d[i] = shift_q[i + 1];
        end
        shift_d[DATA_W-1] = in;
    end

    // In STOP the accumulator already holds the data bits XORed with the parity bit.
`ifdef SERIAL_PARITY_RX_EVEN_EN
    always_comb perr_d = acc_q;
`else
    always_comb perr_d = ~acc_q;
`endif

    // Frame state machine. The outputs are registered, so done and perr are
    // set on the edge that enters DONE.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            shift_q    <= '0;
            acc_q      <= 1'b0;
            out_byte_q <= '0;
            done_q     <= 1'b0;
            perr_q     <= 1'b0;
        end else begin
            // done and perr are strobes. Every state except the one entering DONE clears them.
            done_q <= 1'b0;
            perr_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (!in) begin
                        state_q <= S_DATA;
                        cnt_q   <= '0;
                        acc_q   <= 1'b0;
                    end
                end
                S_DATA: begin
                    shift_q <= shift_d;
                    acc_q   <= acc_q ^ in;
                    if (cnt_q == C_LAST) begin
                        cnt_q   <= '0;
                        state_q <= S_PARITY;
                    end else begin
                        cnt_q   <= cnt_q + C_ONE;
                    end
                end
                S_PARITY: begin
                    acc_q   <= acc_q ^ in;
                    state_q <= S_STOP;
                end
                S_STOP: begin
                    if (in) begin
                        state_q    <= S_DONE;
                        done_q     <= 1'b1;
                        perr_q     <= perr_d;
                        out_byte_q <= shift_q;
                    end else begin
                        // Framing error: the frame is discarded.
                        state_q <= S_WAIT;
                    end
                end
                S_DONE: begin
                    // A low line bit here is the start bit of the next frame.
                    if (!in) begin
                        state_q <= S_DATA;
                        cnt_q   <= '0;
                        acc_q   <= 1'b0;
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                S_WAIT: begin
                    if (in) begin
                        state_q <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign out_byte = out_byte_q;
    assign done     = done_q;
    assign perr     = perr_q;

endmodule
`default_nettype wire

// File: tb/tb_serial_parity_rx.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_parity_rx
// Brief    : Scoreboard testbench for serial_parity_rx. Stimulus pushes the
//            expected word, perr, and done cycle into a queue. A monitor pops
//            and compares the queue on every done strobe.
// Revision : 1.0 - initial release
// ============================================================================
module tb_serial_parity_rx;

    localparam int DATA_W = 8;

    logic              clk;
    logic              reset;
    logic              in;
    logic [DATA_W-1:0] out_byte;
    logic              done;
    logic              perr;

    int checks;
    int errors;
    int cyc;

    typedef struct {
        logic [DATA_W-1:0] data;
        logic              perr;
        int                cyc;
    } exp_t;

    exp_t sb[$];

    serial_parity_rx #(.DATA_W(DATA_W)) dut (
        .clk      (clk),
        .reset    (reset),
        .in       (in),
        .out_byte (out_byte),
        .done     (done),
        .perr     (perr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: sample on the falling edge and compare every done strobe against the queue head.
    always @(negedge clk) begin
        if (done === 1'b1) begin
            if (sb.size() == 0) begin
                errors++;
                checks++;
                $display("FAIL spurious_done: done=1 at cycle %0d with nothing expected, out_byte=%h", cyc, out_byte);
            end else begin
                exp_t e;
                e = sb.pop_front();
                checks++;
                if (out_byte !== e.data) begin
                    errors++;
                    $display("FAIL out_byte: got %h expected %h", out_byte, e.data);
                end
                checks++;
                if (perr !== e.perr) begin
                    errors++;
                    $display("FAIL perr: got %b expected %b (data %h)", perr, e.perr, e.data);
                end
                checks++;
                if (cyc != e.cyc) begin
                    errors++;
                    $display("FAIL done_timing: got cycle %0d expected %0d", cyc, e.cyc);
                end
            end
        end else if (done !== 1'b0 || perr !== 1'b0) begin
            errors++;
            checks++;
            $display("FAIL idle_outputs: done=%b perr=%b expected 0/0", done, perr);
        end
    end

    // Drive one line bit. The following posedge samples it.
    task automatic send_bit(input logic b);
        @(negedge clk);
        in = b;
    endtask

    // Build the expected parity error from the number of ones on the line.
    function automatic logic calc_perr(input logic [DATA_W-1:0] d, input logic p);
        int ones;
        ones = $countones(d) + int'(p);
`ifdef SERIAL_PARITY_RX_EVEN_EN
        return (ones % 2) != 0;
`else
        return (ones % 2) == 0;
`endif
    endfunction

    // Send a complete frame. A frame with a good stop bit also queues the
    // response expected 10 edges after the edge that samples the start bit.
    task automatic send_frame(input logic [DATA_W-1:0] d, input logic p, input logic stop);
        exp_t e;
        @(negedge clk);
        in = 1'b0;
        if (stop) begin
            e.data = d;
            e.perr = calc_perr(d, p);
            e.cyc  = cyc + 1 + DATA_W + 2;
            sb.push_back(e);
        end
        for (int i = 0; i < DATA_W; i++) begin
            send_bit(d[i]);
        end
        send_bit(p);
        send_bit(stop);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) send_bit(1'b1);
    endtask

    task automatic check_val(input string name, input logic [DATA_W-1:0] got, input logic [DATA_W-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    initial begin
        logic [DATA_W-1:0] c_zero;
        c_zero = '0;
        cyc    = 0;
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        in     = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_val("reset_out_byte", out_byte, c_zero);
        check_val("reset_done", {7'd0, done}, c_zero);
        check_val("reset_perr", {7'd0, perr}, c_zero);
        reset = 1'b0;
        idle(2);

`ifdef SERIAL_PARITY_RX_EVEN_EN
        // Even-parity build: A5 has four ones.
        send_frame(8'hA5, 1'b0, 1'b1);
        idle(2);
        send_frame(8'hA5, 1'b1, 1'b1);
        idle(2);
`else
        // Good frame, then the same frame with a bad parity bit.
        send_frame(8'hA5, 1'b1, 1'b1);
        idle(2);
        send_frame(8'hA5, 1'b0, 1'b1);
        idle(2);
`endif

        // Framing error: the line is held low in WAIT, then a good frame follows.
        send_frame(8'h3C, 1'b0, 1'b0);
        repeat (5) send_bit(1'b0);
        idle(2);
        send_frame(8'h01, 1'b0, 1'b1);
        idle(2);

        // Back to back: the second start bit falls in the done cycle.
        send_frame(8'hFF, 1'b1, 1'b1);
        send_frame(8'h00, 1'b1, 1'b1);
        idle(2);

        // Reset during data bit 4 discards the frame and clears out_byte.
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        idle(1);
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'(8'h5A >> i));
        @(negedge clk);
        in    = 1'(8'h5A >> 4);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        in    = 1'b1;
        idle(12);
        check_val("midframe_reset_out_byte", out_byte, c_zero);
        send_frame(8'h5A, 1'b1, 1'b1);
        idle(2);

        // Wait for the scoreboard to drain, with a bounded wait.
        for (int i = 0; i < 50 && sb.size() != 0; i++) @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expected frames never reported, expected 0", sb.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
